// File: rtl/time_uart_tx_if.sv
// Time-of-day UART transmitter bus: BCD time in, trigger controls, serial line and status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; send is dropped by the transmitter while busy.
//
// master drives data_ch/send/auto_en and observes tx/busy/done; slave is the transmitter.
interface time_uart_tx_if;
    logic [23:0] data_ch;   // HHMMSS as six BCD digits
    logic        send;      // one-cycle transmit request
    logic        auto_en;   // transmit on every change of seconds units
    logic        tx;        // UART line, 8N1, idle high
    logic        busy;      // message in progress
    logic        done;      // one-cycle pulse at message end

    modport master (
        output data_ch, send, auto_en,
        input  tx, busy, done
    );

    modport slave (
        input  data_ch, send, auto_en,
        output tx, busy, done
    );
endinterface

// File: rtl/time_uart_tx.sv
// Sends the current time as the 10-byte ASCII line "HH:MM:SS\r\n" over an 8N1 UART.
// Latency: trigger accepted at edge N drives the start bit and busy from edge N+1; message is 100*BIT_TICKS cycles.
// Backpressure: send while busy is dropped; auto events while busy collapse into one pending message.
//
// Ports: clock, reset (async active-low), bus (time_uart_tx_if.slave: data_ch, send, auto_en, tx, busy, done).
module time_uart_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic           clock,
    input  logic           reset,
    time_uart_tx_if.slave  bus
);
    localparam int RAW_TICKS = CLK_HZ / BAUD;
    localparam int BIT_TICKS = (RAW_TICKS < 2) ? 2 : RAW_TICKS;
    localparam int TW        = $clog2(BIT_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    byte_idx, byte_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [TW-1:0] tick_cnt, tick_nxt;
    logic [23:0]   snap;
    logic [3:0]    prev_sec;
    logic          pending;
    logic          tx_q, tx_nxt;
    logic          done_q;
    logic          tick_end;
    logic          auto_evt;
    logic          trig;
    logic          accept;
    logic          msg_end;
    logic [7:0]    cur_byte;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic [23:0] t);
        logic [7:0] c;
        case (idx)
            4'd0:    c = digit_char(t[23:20]);
            4'd1:    c = digit_char(t[19:16]);
            4'd3:    c = digit_char(t[15:12]);
            4'd4:    c = digit_char(t[11:8]);
            4'd6:    c = digit_char(t[7:4]);
            4'd7:    c = digit_char(t[3:0]);
            4'd8:    c = 8'h0D;
            4'd9:    c = 8'h0A;
            default: c = 8'h3A;   // separators at byte 2 and 5
        endcase
        return c;
    endfunction

    assign tick_end = (tick_cnt == TICK_LAST);
    // prev_sec tracks data_ch every cycle, so an auto event lasts exactly one cycle per change.
    assign auto_evt = bus.auto_en && (bus.data_ch[3:0] != prev_sec);
    assign trig     = bus.send || auto_evt || (pending && bus.auto_en);

    always_comb begin
        state_nxt = state;
        byte_nxt  = byte_idx;
        bit_nxt   = bit_idx;
        tick_nxt  = tick_end ? '0 : tick_cnt + TW'(1);
        accept    = 1'b0;
        msg_end   = 1'b0;
        case (state)
            IDLE: begin
                tick_nxt = '0;
                if (trig) begin
                    state_nxt = START;
                    byte_nxt  = 4'd0;
                    bit_nxt   = 3'd0;
                    accept    = 1'b1;
                end
            end
            START: if (tick_end) state_nxt = DATA;
            DATA: begin
                if (tick_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        bit_nxt   = 3'd0;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick_end) begin
                    if (byte_idx == 4'd9) begin
                        state_nxt = IDLE;
                        byte_nxt  = 4'd0;
                        msg_end   = 1'b1;
                    end else begin
                        state_nxt = START;
                        byte_nxt  = byte_idx + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // tx is registered from the next-state decode so the line never glitches.
        cur_byte = msg_byte(byte_nxt, snap);
        tx_nxt   = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = cur_byte[bit_nxt];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            byte_idx <= 4'd0;
            bit_idx  <= 3'd0;
            tick_cnt <= '0;
            snap     <= 24'd0;
            prev_sec <= 4'd0;
            pending  <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_idx <= byte_nxt;
            bit_idx  <= bit_nxt;
            tick_cnt <= tick_nxt;
            tx_q     <= tx_nxt;
            done_q   <= msg_end;
            prev_sec <= bus.data_ch[3:0];
            if (accept) snap <= bus.data_ch;
            // Pending is only armed while a message is running; in IDLE the event starts one directly.
            if (!bus.auto_en)                    pending <= 1'b0;
            else if (state != IDLE && auto_evt)  pending <= 1'b1;
            else if (accept)                     pending <= 1'b0;
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_time_uart_tx.sv
// Self-checking bench for time_uart_tx at CLK_HZ=8, BAUD=1 (8 cycles per bit).
// Latency: a UART decoder pops expected bytes from a queue filled when each message is requested.
// Backpressure: covers dropped send while busy, pending auto messages and mid-message reset.
module tb_time_uart_tx;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp_q[$];

    time_uart_tx_if bus();

    time_uart_tx #(.CLK_HZ(8), .BAUD(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    task automatic push_time(input logic [23:0] t);
        exp_q.push_back(ascii_digit(t[23:20]));
        exp_q.push_back(ascii_digit(t[19:16]));
        exp_q.push_back(8'h3A);
        exp_q.push_back(ascii_digit(t[15:12]));
        exp_q.push_back(ascii_digit(t[11:8]));
        exp_q.push_back(8'h3A);
        exp_q.push_back(ascii_digit(t[7:4]));
        exp_q.push_back(ascii_digit(t[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // UART decoder: samples each bit in its middle and scores it against the expected queue.
    task automatic monitor_tx();
        int         cnt = 0;
        bit         on  = 1'b0;
        logic [7:0] rx  = 8'h00;
        logic [7:0] exp_b;
        forever begin
            @(negedge clock);
            if (!reset) begin
                on  = 1'b0;
                cnt = 0;
            end else if (!on) begin
                if (bus.tx === 1'b0) begin
                    on  = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt == 4) begin
                    total++;
                    if (bus.tx !== 1'b0) begin
                        bad++;
                        $display("FAIL start_bit: tx=%b required 0", bus.tx);
                    end
                end else if (cnt >= 12 && cnt <= 68 && (cnt % 8) == 4) begin
                    rx[(cnt - 12) / 8] = bus.tx;
                end else if (cnt == 76) begin
                    total++;
                    if (bus.tx !== 1'b1) begin
                        bad++;
                        $display("FAIL stop_bit: tx=%b required 1", bus.tx);
                    end
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL byte: got %h, none expected", rx);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (rx !== exp_b) begin
                            bad++;
                            $display("FAIL byte: got %h required %h", rx, exp_b);
                        end
                    end
                end
                if (cnt == 79) on = 1'b0;
            end
        end
    endtask

    task automatic start_send(input string name);
        @(negedge clock);
        bus.send = 1'b1;
        @(negedge clock);
        bus.send = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.tx !== 1'b0) begin
            bad++;
            $display("FAIL %s_latency: busy=%b tx=%b required busy=1 tx=0", name, bus.busy, bus.tx);
        end
    endtask

    // seen = negedges already observed with busy high for this message.
    task automatic wait_msg(input string name, input int seen);
        int n = seen;
        bit timed_out = 1'b0;
        while (bus.busy === 1'b1) begin
            if (n >= 1000) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clock);
            if (bus.busy === 1'b1) n++;
        end
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL %s_timeout: busy still high after %0d cycles", name, n);
        end
        total++;
        if (n != 800) begin
            bad++;
            $display("FAIL %s_busy_len: busy for %0d cycles required 800", name, n);
        end
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: done=%b when busy fell, required 1", name, bus.done);
        end
        @(negedge clock);
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_width: done=%b one cycle later, required 0", name, bus.done);
        end
    endtask

    task automatic expect_idle(input string name, input int cycles);
        bit saw = 1'b0;
        repeat (cycles) begin
            @(negedge clock);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tx !== 1'b1) saw = 1'b1;
        end
        total++;
        if (saw) begin
            bad++;
            $display("FAIL %s_idle: activity seen, required idle for %0d cycles", name, cycles);
        end
    endtask

    task automatic check_queue(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_queue: %0d bytes not received, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        bus.data_ch = 24'h000000;
        bus.send    = 1'b0;
        bus.auto_en = 1'b0;
        reset       = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if (bus.tx !== 1'b1) begin bad++; $display("FAIL reset_tx: tx=%b required 1", bus.tx); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: busy=%b required 0", bus.busy); end
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: done=%b required 0", bus.done); end
        reset = 1'b1;
        expect_idle("reset", 10);
    endtask

    task automatic test_basic();
        bus.data_ch = 24'h235907;
        push_time(24'h235907);
        start_send("basic");
        wait_msg("basic", 1);
        check_queue("basic");
    endtask

    task automatic test_invalid_digit();
        bus.data_ch = 24'h1A0000;
        push_time(24'h1A0000);
        start_send("invalid");
        wait_msg("invalid", 1);
        check_queue("invalid");
    endtask

    task automatic test_snapshot_and_drop();
        bus.data_ch = 24'h120000;
        push_time(24'h120000);
        start_send("snap");
        repeat (49) @(negedge clock);
        bus.data_ch = 24'h130000;
        repeat (350) @(negedge clock);
        bus.send = 1'b1;            // dropped: transmitter is busy
        @(negedge clock);
        bus.send = 1'b0;
        wait_msg("snap", 401);
        expect_idle("snap_drop", 200);
        check_queue("snap");
    endtask

    task automatic test_auto_pending();
        bus.data_ch = 24'h120000;
        @(negedge clock);
        bus.auto_en = 1'b1;
        push_time(24'h120000);
        start_send("auto1");
        repeat (99) @(negedge clock);
        bus.data_ch = 24'h120001;
        repeat (100) @(negedge clock);
        bus.data_ch = 24'h120002;
        push_time(24'h120002);      // merged pending message carries the latest value
        repeat (100) @(negedge clock);
        bus.send = 1'b1;
        @(negedge clock);
        bus.send = 1'b0;
        wait_msg("auto1", 301);
        total++;
        if (bus.busy !== 1'b1 || bus.tx !== 1'b0) begin
            bad++;
            $display("FAIL auto_pending_start: busy=%b tx=%b after done, required busy=1 tx=0", bus.busy, bus.tx);
        end
        wait_msg("auto2", 1);
        expect_idle("auto_after", 200);
        check_queue("auto");
    endtask

    task automatic test_auto_cancel();
        push_time(24'h120002);
        start_send("cancel");
        repeat (99) @(negedge clock);
        bus.data_ch = 24'h120003;
        repeat (100) @(negedge clock);
        bus.auto_en = 1'b0;
        wait_msg("cancel", 200);
        expect_idle("cancel_after", 200);
        check_queue("cancel");
    endtask

    task automatic test_send_and_auto_same_cycle();
        bus.auto_en = 1'b1;
        repeat (2) @(negedge clock);
        push_time(24'h120004);
        @(negedge clock);
        bus.data_ch = 24'h120004;
        bus.send    = 1'b1;
        @(negedge clock);
        bus.send    = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.tx !== 1'b0) begin
            bad++;
            $display("FAIL coincide_latency: busy=%b tx=%b required busy=1 tx=0", bus.busy, bus.tx);
        end
        wait_msg("coincide", 1);
        expect_idle("coincide_after", 200);
        check_queue("coincide");
        bus.auto_en = 1'b0;
    endtask

    task automatic test_reset_mid_message();
        bus.data_ch = 24'h235907;
        exp_q.push_back(8'h32);     // only three bytes complete before reset
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h3A);
        start_send("abort");
        repeat (299) @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_async: tx=%b busy=%b required tx=1 busy=0", bus.tx, bus.busy);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        expect_idle("abort_after", 300);
        check_queue("abort");
    endtask

    task automatic test_after_reset();
        bus.data_ch = 24'h084512;
        push_time(24'h084512);
        start_send("post_reset");
        wait_msg("post_reset", 1);
        check_queue("post_reset");
    endtask

    initial begin
        fork
            monitor_tx();
        join_none
        test_reset();
        test_basic();
        test_invalid_digit();
        test_snapshot_and_drop();
        test_auto_pending();
        test_auto_cancel();
        test_send_and_auto_same_cycle();
        test_reset_mid_message();
        test_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/time_uart_tx.md
TIME_UART_TX -- requirements
Module: time_uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; BIT_TICKS = CLK_HZ/BAUD (integer divide, minimum 2).
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_ch  input  24  current time as 6 BCD digits: [23:20] hours tens, [19:16] hours units, [15:12] minutes tens, [11:8] minutes units, [7:4] seconds tens, [3:0] seconds units.
REQ-006 send  input  1  one-cycle request to transmit the current time.
REQ-007 auto_en  input  1  level; when 1, each change of seconds also triggers a transmission.
REQ-008 tx  output  1  UART line, 8N1, idle high.
REQ-009 busy  output  1  high while a message is in progress.
REQ-010 done  output  1  one-cycle pulse at message end.

Function
REQ-011 A message SHALL be exactly 10 bytes, in order: H1, H0, 0x3A ':', M1, M0, 0x3A, S1, S0, 0x0D, 0x0A.
REQ-012 Each digit byte SHALL be 0x30 + digit for digit 0..9, and 0x3F '?' for digit values 10..15.
REQ-013 data_ch SHALL be snapshotted into an internal register in the cycle the trigger is accepted; later changes of data_ch SHALL NOT affect the message in flight.
REQ-014 Each byte SHALL be framed as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), every bit held for exactly BIT_TICKS cycles.
REQ-015 Bytes SHALL be sent back-to-back with no idle gap between the stop bit of one byte and the start bit of the next.
REQ-016 The state machine SHALL have states IDLE, START, DATA, STOP, with a 4-bit byte index (0..9) and a 3-bit bit index (0..7).
REQ-017 IDLE -> START on an accepted trigger.
REQ-018 START -> DATA after BIT_TICKS cycles.
REQ-019 DATA -> STOP after 8 bits.
REQ-020 STOP -> START (byte index +1) after BIT_TICKS cycles if byte index < 9, otherwise STOP -> IDLE.
REQ-021 Latency: a trigger accepted at rising edge N SHALL drive tx low and busy high from edge N+1.
REQ-022 A message SHALL occupy exactly 100*BIT_TICKS cycles of busy high.
REQ-023 At the end of the final stop bit, busy SHALL fall and done SHALL pulse high for exactly one cycle in the same cycle.
REQ-024 Auto trigger: a register SHALL hold the previous data_ch[3:0]; when auto_en=1 and data_ch[3:0] differs from it, an auto event SHALL occur. The register SHALL update every cycle regardless of auto_en.
REQ-025 send asserted while busy SHALL be ignored (dropped, not queued).
REQ-026 An auto event while busy SHALL set a 1-deep pending flag. When the current message finishes, the pending flag SHALL start a new message in the cycle after done, using a fresh snapshot. Further auto events while the flag is set SHALL merge into it.
REQ-027 Clearing auto_en SHALL clear the pending flag.
REQ-028 send and an auto event in the same idle cycle SHALL start a single message.

Reset
REQ-029 While reset=0: tx=1, busy=0, done=0, state=IDLE, all counters 0, pending=0, snapshot=0, previous-seconds register=0.
REQ-030 Reset asserted mid-message SHALL abort the message immediately; tx=1 asynchronously. No done pulse SHALL follow reset release.
REQ-031 The first trigger after reset release SHALL produce a complete, correctly framed message.

Verification (CLK_HZ=8, BAUD=1 -> BIT_TICKS=8)
REQ-032 data_ch=0x235907, send pulse -> tx decodes to "23:59:07\r\n", busy high for 800 cycles, then a single done pulse.
REQ-033 data_ch=0x1A0000, send -> first two bytes are 0x31, 0x3F; the remaining bytes are as REQ-011.
REQ-034 send, then data_ch changes from 0x120000 to 0x130000 at cycle 50 -> message reads "12:00:00\r\n".
REQ-035 auto_en=1 with data_ch seconds stepping 00->01 and 01->02 during one message -> exactly one extra message, starting the cycle after done, carrying the latest value; a send pulse while busy produces no extra message.
REQ-036 reset pulled low at cycle 300 of a message -> tx=1, busy=0 immediately; with no new trigger, tx stays high and done never pulses.
